// File: rtl/dram_pkg.sv
// Shared types and widths for the DRAM multiplexed-address responder.
package dram_pkg;

  localparam int AW_DEFAULT     = 9;
  localparam int ADDR_W_DEFAULT = 2 * AW_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    COL,
    CBR
  } dram_state_t;

  // Width of the rebuilt {row, col} word address for a given mux width.
  function automatic int addr_width(input int aw);
    return 2 * aw;
  endfunction

endpackage

// File: rtl/dram_addr_demux_strobe_edge.sv
// Registered fall/rise detector for one active-low DRAM strobe.
module strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic fall,
  output logic rise
);

  logic strobe_q;
  logic armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b1;
      armed    <= 1'b0;
    end else begin
      strobe_q <= strobe_n;
      armed    <= armed | strobe_n;
    end
  end

  // A strobe held low through reset must first return high before its
  // next low level counts as a fall.
  assign fall = armed & strobe_q & ~strobe_n;
  assign rise = strobe_n & ~strobe_q;

endmodule

// File: rtl/dram_addr_demux.sv
// Rebuilds {row, col} from RAS_n/CAS_n-strobed mux address, classifies
// accesses vs refreshes. Page-mode bursts enabled by DRAM_FAST_PAGE_EN.
module dram_addr_demux
  import dram_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AW-1:0]               ma,
  input  logic                        ras_n,
  input  logic                        cas_n,
  input  logic                        we_n,
  output logic                        req_valid,
  output logic [addr_width(AW)-1:0]   req_addr,
  output logic                        req_we,
  input  logic                        req_ready,
  output logic                        refresh,
  output logic                        overrun
);

  dram_state_t   state;
  logic [AW-1:0] row;
  logic          cas_seen;
  logic          ras_fall, ras_rise, cas_fall, cas_rise;
  logic          page_open;
  logic          issue;
  logic [AW-1:0] issue_row;

  strobe_edge u_ras_edge (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (ras_n),
    .fall     (ras_fall),
    .rise     (ras_rise)
  );

  strobe_edge u_cas_edge (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (cas_n),
    .fall     (cas_fall),
    .rise     (cas_rise)
  );

`ifdef DRAM_FAST_PAGE_EN
  assign page_open = 1'b1;
`else
  // Only the first CAS fall of a RAS cycle may issue.
  assign page_open = ~cas_seen;
`endif

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    issue     = 1'b0;
    issue_row = row;
    case (state)
      IDLE: if (ras_fall && cas_fall) begin
        issue     = 1'b1;
        issue_row = ma;
      end
      ROW:  if (cas_fall && page_open) issue = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      cas_seen  <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      refresh   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      refresh <= 1'b0;
      overrun <= 1'b0;

      // Column and we_n land directly in the request fields; an access that
      // arrives while the previous one is still unaccepted is dropped.
      if (issue) begin
        row      <= issue_row;
        cas_seen <= 1'b1;
        if (!req_valid || req_ready) begin
          req_valid <= 1'b1;
          req_addr  <= {issue_row, ma};
          req_we    <= ~we_n;
        end else begin
          overrun <= 1'b1;
        end
      end else if (req_valid && req_ready) begin
        req_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ras_fall && cas_fall) begin
            state <= COL;
          end else if (ras_fall && cas_n) begin
            row   <= ma;
            state <= ROW;
          end else if (cas_fall && ras_n) begin
            state <= CBR;
          end
        end
        ROW: begin
          if (cas_fall && page_open) begin
            state <= COL;
          end else if (ras_rise) begin
            // A RAS cycle that never issued an access is a RAS-only refresh.
            if (!cas_seen) refresh <= 1'b1;
            cas_seen <= 1'b0;
            state    <= IDLE;
          end
        end
        COL: begin
          if (ras_rise) begin
            cas_seen <= 1'b0;
            state    <= IDLE;
          end else if (cas_rise) begin
            state <= ROW;
          end
        end
        CBR: begin
          if (ras_fall) refresh <= 1'b1;
          if (cas_rise || (ras_n && cas_n)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
